// File: rtl/csa_16.sv
// csa_16: 16-bit conditional-sum adder with registered sum and carry-out
module csa_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] s0 [5];
  logic [15:0] s1 [5];
  logic [15:0] c0 [5];
  logic [15:0] c1 [5];
  // Level l holds groups of 2^l bits; c0/c1 are indexed by group, sums by bit
  always_comb begin
    s0[0] = a ^ b;
    s1[0] = ~(a ^ b);
    c0[0] = a & b;
    c1[0] = a | b;
    for (int l = 0; l < 4; l++) begin
      s0[l+1] = s0[l];
      s1[l+1] = s1[l];
      c0[l+1] = '0;
      c1[l+1] = '0;
      for (int k = 0; k < (8 >> l); k++) begin
        for (int i = 0; i < (1 << l); i++) begin
          s0[l+1][(2*k+1)*(1<<l)+i] = c0[l][2*k] ? s1[l][(2*k+1)*(1<<l)+i] : s0[l][(2*k+1)*(1<<l)+i];
          s1[l+1][(2*k+1)*(1<<l)+i] = c1[l][2*k] ? s1[l][(2*k+1)*(1<<l)+i] : s0[l][(2*k+1)*(1<<l)+i];
        end
        c0[l+1][k] = c0[l][2*k] ? c1[l][2*k+1] : c0[l][2*k+1];
        c1[l+1][k] = c1[l][2*k] ? c1[l][2*k+1] : c0[l][2*k+1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      cout <= 1'b0;
    end else begin
      s <= cin ? s1[4] : s0[4];
      cout <= cin ? c1[4][0] : c0[4][0];
    end
  end
endmodule

// File: tb/tb_csa_16.sv
// tb_csa_16: directed and back-to-back random checks of the registered adder
module tb_csa_16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] s;
  logic        cout;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [16:0] exp_v;

  csa_16 dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s), .cout(cout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] expv);
    n_chk++;
    assert ({cout, s} === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, {cout, s}, expv);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] x, input logic [15:0] y, input logic c);
    rst = r; a = x; b = y; cin = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1); chk("reset1", 17'h00000);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1); chk("reset2", 17'h00000);
    step(1'b0, 16'h99CD, 16'h36D6, 1'b0); chk("mixed_c0", 17'h0D0A3);
    step(1'b0, 16'h99CD, 16'h36D6, 1'b1); chk("mixed_c1", 17'h0D0A4);
    step(1'b0, 16'hFFFF, 16'h0000, 1'b1); chk("prop_cin", 17'h10000);
    step(1'b0, 16'hFFFF, 16'h0001, 1'b0); chk("prop_b", 17'h10000);
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1); chk("max", 17'h1FFFF);
    step(1'b0, 16'h8000, 16'h8000, 1'b0); chk("msb", 17'h10000);
    step(1'b0, 16'h0000, 16'h0000, 1'b0); chk("zero", 17'h00000);
    step(1'b0, 16'h5555, 16'hAAAA, 1'b1); chk("alt", 17'h10000);
    step(1'b0, 16'h1234, 16'h4321, 1'b0); chk("plain", 17'h05555);
    step(1'b1, 16'h1234, 16'h4321, 1'b1); chk("mid_reset", 17'h00000);
    step(1'b0, 16'h00FF, 16'h0001, 1'b0); chk("after_reset", 17'h00100);
    for (int i = 0; i < 1000; i++) begin
      rst = (i == 500);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      exp_v = rst ? 17'h0 : {1'b0, a} + {1'b0, b} + {16'h0, cin};
      @(posedge clk);
      #1;
      chk(i == 500 ? "rand_reset" : "rand", exp_v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
